// File: rtl/tbuf_arb_pkg.sv
// Shared types and constants for the tristate bus arbiter.
package tbuf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int TURN_W  = 3;
  localparam int OWNER_W = 3;

  // Next round-robin start index after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    if (idx >= n - 1) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/tbuf_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// found by a priority encode over the request vector doubled and masked below ptr.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] one_hot,
  output logic [PTR_W-1:0] index,
  output logic             any
);

  logic [2*N_REQ-1:0] masked;
  logic               found;

  // Mask the low copy below ptr, then take the lowest set bit of the doubled vector.
  always_comb begin
    masked  = {req, req};
    found   = 1'b0;
    index   = {PTR_W{1'b0}};
    one_hot = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (i < int'(ptr)) begin
        masked[i] = 1'b0;
      end else begin
        masked[i] = req[i];
      end
    end
    for (int i = 0; i < 2 * N_REQ; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        index = PTR_W'(i % N_REQ);
      end else begin
        found = found;
      end
    end
    any = found;
    if (found) begin
      one_hot[index] = 1'b1;
    end else begin
      one_hot = {N_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner arbiter for a shared tristate net with a forced
// all-off turnaround between owners and a bounded hold time under contention.
module tbuf_bus_arbiter
  import tbuf_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] oen_n,
  output logic [2:0]       owner,
  output logic             busy,
  output logic             preempt
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD);

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [TURN_W-1:0]   turn_cnt;

  logic [N_REQ-1:0]    pick_one_hot;
  logic [PTR_W-1:0]    pick_index;
  logic                pick_any;

  logic [PTR_W-1:0]    owner_idx;
  logic                owner_req;
  logic                contender;
  logic                hold_at_max;
  logic                turn_done;
  logic [PTR_W-1:0]    next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .one_hot (pick_one_hot),
    .index   (pick_index),
    .any     (pick_any)
  );

  // Release conditions and rotation pointer derived from the current owner.
  always_comb begin
    owner_idx   = owner[PTR_W-1:0];
    owner_req   = req[owner_idx];
    contender   = |(req & ~gnt);
    hold_at_max = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    turn_done   = (turn_cnt == TURN_W'(TURNAROUND - 1));
    next_ptr    = PTR_W'(rr_next(int'(owner_idx), N_REQ));
  end

  // Arbiter FSM; gnt and oen_n are driven only from these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= {N_REQ{1'b0}};
      oen_n    <= {N_REQ{1'b1}};
      owner    <= 3'd0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      rr_ptr   <= {PTR_W{1'b0}};
      hold_cnt <= {HOLD_W{1'b0}};
      turn_cnt <= {TURN_W{1'b0}};
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= GRANT;
            gnt      <= pick_one_hot;
            oen_n    <= ~pick_one_hot;
            owner    <= OWNER_W'(pick_index);
            busy     <= 1'b1;
            hold_cnt <= {HOLD_W{1'b0}};
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // A voluntary drop wins over a coincident hold-limit preempt.
          if (!owner_req || (hold_at_max && contender)) begin
            state    <= TURN;
            gnt      <= {N_REQ{1'b0}};
            oen_n    <= {N_REQ{1'b1}};
            busy     <= 1'b0;
            preempt  <= owner_req;
            rr_ptr   <= next_ptr;
            turn_cnt <= {TURN_W{1'b0}};
          end else if (!hold_at_max) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end else begin
            hold_cnt <= hold_cnt;
          end
        end
        TURN: begin
          if (turn_done) begin
            if (pick_any) begin
              state    <= GRANT;
              gnt      <= pick_one_hot;
              oen_n    <= ~pick_one_hot;
              owner    <= OWNER_W'(pick_index);
              busy     <= 1'b1;
              hold_cnt <= {HOLD_W{1'b0}};
            end else begin
              state <= IDLE;
            end
          end else begin
            turn_cnt <= turn_cnt + TURN_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= {N_REQ{1'b0}};
          oen_n <= {N_REQ{1'b1}};
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Directed plus random bench for tbuf_bus_arbiter: a TURNAROUND=1 instance
// and a TURNAROUND=3 instance, scoreboard of per-cycle expectations and
// continuous invariant monitoring.
module tb_tbuf_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst3;
  logic [3:0] req, req3;
  logic [3:0] gnt, gnt3, oen_n, oen_n3;
  logic [2:0] owner, owner3;
  logic       busy, busy3, preempt, preempt3;

  int total = 0;
  int bad = 0;
  int preempt_seen = 0;
  logic mon_on = 1'b0;

  logic [3:0] prev_a = 4'd0, prev_b = 4'd0;
  logic       had_a = 1'b0, had_b = 1'b0;
  int         zrun_a = 0, zrun_b = 0;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic       busy;
    logic       preempt;
  } exp_t;
  exp_t sbq[$];

  tbuf_bus_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .oen_n(oen_n),
    .owner(owner), .busy(busy), .preempt(preempt)
  );

  tbuf_bus_arbiter #(.N_REQ(4), .TURNAROUND(3), .MAX_HOLD(8)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .gnt(gnt3), .oen_n(oen_n3),
    .owner(owner3), .busy(busy3), .preempt(preempt3)
  );

  function automatic logic [2:0] oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic chk(input string tag, input string field, input logic [3:0] act, input logic [3:0] expv);
    total++;
    assert (act === expv) else begin
      bad++;
      $error("FAIL %s.%s actual=%b expected=%b", tag, field, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input logic sel);
    exp_t e;
    logic [3:0] ag, ao;
    logic [2:0] aw;
    logic ab, ap;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty actual=0 entries expected=1 entry");
    end else begin
      e  = sbq.pop_front();
      ag = sel ? gnt3 : gnt;
      ao = sel ? oen_n3 : oen_n;
      aw = sel ? owner3 : owner;
      ab = sel ? busy3 : busy;
      ap = sel ? preempt3 : preempt;
      if (!sel && ap === 1'b1) preempt_seen++;
      chk(e.tag, "gnt", ag, e.gnt);
      chk(e.tag, "oen_n", ao, ~e.gnt);
      chk(e.tag, "busy", {3'd0, ab}, {3'd0, e.busy});
      chk(e.tag, "preempt", {3'd0, ap}, {3'd0, e.preempt});
      if (e.busy) chk(e.tag, "owner", {1'b0, aw}, {1'b0, oh2idx(e.gnt)});
    end
  endtask

  // Push the expectation for the coming edge, advance, then compare.
  task automatic cyc(input logic sel, input string tag, input logic [3:0] g, input logic b, input logic p);
    exp_t e;
    e.tag = tag;
    e.gnt = g;
    e.busy = b;
    e.preempt = p;
    sbq.push_back(e);
    tick();
    pop_check(sel);
  endtask

  task automatic inv(input string tag, input logic [3:0] g, input logic [3:0] o, input logic r,
                     input int ta, inout logic [3:0] prev, inout logic had, inout int zrun);
    total++;
    assert ($countones(g) <= 1) else begin
      bad++;
      $error("FAIL %s.onehot actual=%b expected=at most one bit", tag, g);
    end
    chk(tag, "oen_inv", o, ~g);
    if (r) begin
      had = 1'b0;
      zrun = 0;
    end else if (g == 4'd0) begin
      zrun++;
    end else begin
      if (g != prev) begin
        total++;
        assert (prev == 4'd0 && (!had || zrun >= ta)) else begin
          bad++;
          $error("FAIL %s.gap actual=%0d zero cycles (prev=%b) expected>=%0d", tag, zrun, prev, ta);
        end
      end
      had = 1'b1;
      zrun = 0;
    end
    prev = g;
  endtask

  // Invariants on both instances every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_on) begin
      inv("inv_a", gnt, oen_n, rst, 1, prev_a, had_a, zrun_a);
      inv("inv_b", gnt3, oen_n3, rst3, 3, prev_b, had_b, zrun_b);
    end
  end

  initial begin
    rst = 1'b1; rst3 = 1'b1; req = 4'd0; req3 = 4'd0;
    tick();
    cyc(1'b0, "reset_a", 4'd0, 1'b0, 1'b0);
    chk("reset_a", "owner", {1'b0, owner}, 4'd0);
    pop_check_b_reset: begin
      cyc(1'b1, "reset_b", 4'd0, 1'b0, 1'b0);
    end
    rst = 1'b0; rst3 = 1'b0;
    mon_on = 1'b1;

    // Single requester
    for (int i = 0; i < 3; i++) cyc(1'b0, "t1_idle", 4'd0, 1'b0, 1'b0);
    req = 4'b0010;
    cyc(1'b0, "t1_grant", 4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, "t1_hold", 4'b0010, 1'b1, 1'b0);
    req = 4'b0000;
    cyc(1'b0, "t1_drop", 4'd0, 1'b0, 1'b0);
    cyc(1'b0, "t1_turn", 4'd0, 1'b0, 1'b0);
    cyc(1'b0, "t1_idle2", 4'd0, 1'b0, 1'b0);

    // Rotation with preemption, all four requesting
    rst = 1'b1;
    cyc(1'b0, "t2_rst", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    preempt_seen = 0;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) cyc(1'b0, "t2_own", 4'b0001 << k, 1'b1, 1'b0);
      cyc(1'b0, "t2_preempt", 4'd0, 1'b0, 1'b1);
    end
    cyc(1'b0, "t2_wrap", 4'b0001, 1'b1, 1'b0);
    chk("t2_count", "preempts", 4'(preempt_seen), 4'd4);
    req = 4'b0000;
    cyc(1'b0, "t2_rel", 4'd0, 1'b0, 1'b0);
    cyc(1'b0, "t2_idle", 4'd0, 1'b0, 1'b0);

    // No contender: long hold, no preempt
    req = 4'b0100;
    for (int i = 0; i < 40; i++) cyc(1'b0, "t3_hold", 4'b0100, 1'b1, 1'b0);
    req = 4'b0000;
    cyc(1'b0, "t3_rel", 4'd0, 1'b0, 1'b0);
    cyc(1'b0, "t3_idle", 4'd0, 1'b0, 1'b0);

    // Reset mid-grant
    req = 4'b1000;
    cyc(1'b0, "t5_grant", 4'b1000, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, "t5_hold", 4'b1000, 1'b1, 1'b0);
    rst = 1'b1;
    req = 4'b1001;
    cyc(1'b0, "t5_rst", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, "t5_after", 4'b0001, 1'b1, 1'b0);
    req = 4'b0000;
    cyc(1'b0, "t5_rel", 4'd0, 1'b0, 1'b0);
    cyc(1'b0, "t5_idle", 4'd0, 1'b0, 1'b0);

    // Owner drops on the hold-limit cycle while a contender waits
    req = 4'b0011;
    cyc(1'b0, "t6_grant", 4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, "t6_hold", 4'b0010, 1'b1, 1'b0);
    req = 4'b0001;
    cyc(1'b0, "t6_release", 4'd0, 1'b0, 1'b0);
    cyc(1'b0, "t6_next", 4'b0001, 1'b1, 1'b0);
    req = 4'b0000;
    cyc(1'b0, "t6_rel", 4'd0, 1'b0, 1'b0);
    cyc(1'b0, "t6_idle", 4'd0, 1'b0, 1'b0);

    // Three-cycle turnaround instance
    req3 = 4'b0101;
    cyc(1'b1, "t4_grant", 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, "t4_hold", 4'b0001, 1'b1, 1'b0);
    req3 = 4'b0100;
    for (int i = 0; i < 3; i++) cyc(1'b1, "t4_gap", 4'd0, 1'b0, 1'b0);
    cyc(1'b1, "t4_next", 4'b0100, 1'b1, 1'b0);
    cyc(1'b1, "t4_hold2", 4'b0100, 1'b1, 1'b0);
    req3 = 4'b0001;
    for (int i = 0; i < 3; i++) cyc(1'b1, "t4_gap2", 4'd0, 1'b0, 1'b0);
    cyc(1'b1, "t4_back", 4'b0001, 1'b1, 1'b0);
    req3 = 4'b0000;
    cyc(1'b1, "t4_selfgap", 4'd0, 1'b0, 1'b0);
    req3 = 4'b0001;
    for (int i = 0; i < 2; i++) cyc(1'b1, "t4_selfgap", 4'd0, 1'b0, 1'b0);
    cyc(1'b1, "t4_self", 4'b0001, 1'b1, 1'b0);
    req3 = 4'b0000;
    for (int i = 0; i < 4; i++) cyc(1'b1, "t4_idle", 4'd0, 1'b0, 1'b0);

    // Random request stress; invariants monitored continuously
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req3 = 4'($urandom_range(0, 15));
      tick();
    end
    req = 4'd0;
    req3 = 4'd0;
    for (int i = 0; i < 10; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
